// File: rtl/vadd_seq_pkg.sv
// ============================================================================
//  Module   : vadd_seq_pkg
//  Brief    : Shared types, constants and beat-geometry helpers for the
//             vector add/min/max/compare issue sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vadd_seq_pkg;

    // Element-width encoding carried on cmd_sew / alu_sew
    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    // Op-select bit that marks a mask-producing (compare) operation
    localparam int OPSEL_MASK_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Elements carried by one 64-bit beat
    function automatic int unsigned elems_per_beat(input logic [1:0] sew);
        return 32'd8 >> sew;
    endfunction

    // ceil(vl / epb); epb is a power of two so the divide is a shift
    function automatic int unsigned beat_count(input logic [1:0] sew,
                                               input int unsigned vl);
        return (vl + elems_per_beat(sew) - 32'd1) >> (2'd3 - sew);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vadd_seq_if.sv
// ============================================================================
//  Module   : vadd_seq_if
//  Brief    : Command, operand-stream and ALU-issue bundle of the sequencer.
//             master = sequencer side, slave = environment side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vadd_seq_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 9,
    parameter int VL_WIDTH    = 16
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OPSEL_WIDTH-1:0] cmd_opsel;
    logic [1:0]             cmd_sew;
    logic [VL_WIDTH-1:0]    cmd_vl;
    logic [ADDR_WIDTH-1:0]  cmd_addr;

    logic                   opnd_valid;
    logic                   opnd_ready;
    logic [DATA_WIDTH-1:0]  opnd_vec0;
    logic [DATA_WIDTH-1:0]  opnd_vec1;

    logic                   alu_valid;
    logic [DATA_WIDTH-1:0]  alu_vec0;
    logic [DATA_WIDTH-1:0]  alu_vec1;
    logic [1:0]             alu_sew;
    logic [OPSEL_WIDTH-1:0] alu_opsel;
    logic [ADDR_WIDTH-1:0]  alu_addr;
    logic [2:0]             alu_start_idx;
    logic                   alu_req_start;
    logic                   alu_req_end;
    logic [BE_WIDTH-1:0]    alu_be;

    logic                   busy;
    logic                   done;

    modport master (
        input  cmd_valid, cmd_opsel, cmd_sew, cmd_vl, cmd_addr,
        input  opnd_valid, opnd_vec0, opnd_vec1,
        output cmd_ready, opnd_ready,
        output alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_addr,
        output alu_start_idx, alu_req_start, alu_req_end, alu_be,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_opsel, cmd_sew, cmd_vl, cmd_addr,
        output opnd_valid, opnd_vec0, opnd_vec1,
        input  cmd_ready, opnd_ready,
        input  alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_addr,
        input  alu_start_idx, alu_req_start, alu_req_end, alu_be,
        input  busy, done
    );

endinterface

`default_nettype wire

// File: rtl/vadd_seq_geom.sv
// ============================================================================
//  Module   : vadd_seq_geom
//  Brief    : Combinational beat geometry: beat count and last-beat
//             byte-enable derived from element width and vector length.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vadd_seq_geom
    import vadd_seq_pkg::*;
#(
    parameter int VL_WIDTH = 16,
    parameter int BE_WIDTH = 8
) (
    input  logic [1:0]          i_sew,
    input  logic [VL_WIDTH-1:0] i_vl,
    output logic [VL_WIDTH-1:0] o_beats,
    output logic [BE_WIDTH-1:0] o_last_be
);

    logic [3:0]          w_epb;
    logic [2:0]          w_elem_mask;
    logic [2:0]          w_vl_m1_lo;
    logic [3:0]          w_last_elems;
    logic [3:0]          w_last_bytes;
    logic [BE_WIDTH-1:0] w_be_shift;

    assign w_epb       = 4'(elems_per_beat(i_sew));
    assign w_elem_mask = 3'(w_epb - 4'd1);

    // epb divides 8, so ((vl-1) mod epb) only needs the low three bits of vl
    assign w_vl_m1_lo   = i_vl[2:0] - 3'd1;
    assign w_last_elems = {1'b0, w_vl_m1_lo & w_elem_mask} + 4'd1;
    assign w_last_bytes = w_last_elems << i_sew;

    // Shifting all-ones by 8 clears the vector, so a full last beat gives FF
    assign w_be_shift = {BE_WIDTH{1'b1}} << w_last_bytes;
    assign o_last_be  = ~w_be_shift;

    assign o_beats = VL_WIDTH'(beat_count(i_sew, 32'(i_vl)));

endmodule

`default_nettype wire

// File: rtl/vadd_issue_seq.sv
// ============================================================================
//  Module   : vadd_issue_seq
//  Brief    : Issue sequencer for the vector add/min/max/compare ALU pipe.
//             Latches one command, issues one ALU beat per operand pair and
//             pulses done once the final beat has left the ALU pipe.
//             Optional macro VADD_SEQ_MASK_EN enables mask-op sequencing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vadd_issue_seq
    import vadd_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 9,
    parameter int VL_WIDTH    = 16,
    parameter int ALU_LATENCY = 6
) (
    input  logic       clk,
    input  logic       rst,
    vadd_seq_if.master bus
);

    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [OPSEL_WIDTH-1:0] r_opsel;
    logic [1:0]             r_sew;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [VL_WIDTH-1:0]    r_beats;
    logic [VL_WIDTH-1:0]    r_beat_idx;
    logic [BE_WIDTH-1:0]    r_last_be;
    logic [CNT_W-1:0]       r_drain_cnt;

    logic [VL_WIDTH-1:0]    w_beats;
    logic [BE_WIDTH-1:0]    w_last_be;
    logic                   w_cmd_hs;
    logic                   w_opnd_hs;
    logic                   w_last_beat;
    logic [ADDR_WIDTH-1:0]  w_beat_addr;
    logic [BE_WIDTH-1:0]    w_beat_be;
    logic [2:0]             w_start_idx;
    logic [DATA_WIDTH-1:0]  w_vec0;
    logic [DATA_WIDTH-1:0]  w_vec1;

    vadd_seq_geom #(
        .VL_WIDTH (VL_WIDTH),
        .BE_WIDTH (BE_WIDTH)
    ) u_geom (
        .i_sew     (bus.cmd_sew),
        .i_vl      (bus.cmd_vl),
        .o_beats   (w_beats),
        .o_last_be (w_last_be)
    );

    assign w_cmd_hs    = bus.cmd_valid  && (r_state == IDLE);
    assign w_opnd_hs   = bus.opnd_valid && (r_state == ISSUE);
    assign w_last_beat = (r_beat_idx == r_beats - VL_WIDTH'(1));
    assign w_vec0      = bus.opnd_vec0;
    assign w_vec1      = bus.opnd_vec1;

`ifdef VADD_SEQ_MASK_EN
    logic w_is_mask;
    assign w_is_mask = r_opsel[OPSEL_MASK_BIT];

    // Per-beat address/enable/start index; mask ops pack 8 beats per byte
    always_comb begin
        w_beat_addr = r_base + (ADDR_WIDTH'(r_beat_idx) << 3);
        w_beat_be   = w_last_beat ? r_last_be : {BE_WIDTH{1'b1}};
        w_start_idx = 3'd0;
        if (w_is_mask) begin
            w_beat_addr = r_base + ADDR_WIDTH'(r_beat_idx >> 3);
            w_beat_be   = {BE_WIDTH{1'b1}};
            w_start_idx = r_beat_idx[2:0];
        end
    end
`else
    // Per-beat address/enable/start index; every op uses data addressing
    always_comb begin
        w_beat_addr = r_base + (ADDR_WIDTH'(r_beat_idx) << 3);
        w_beat_be   = w_last_beat ? r_last_be : {BE_WIDTH{1'b1}};
        w_start_idx = 3'd0;
    end
`endif

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        w_next_state   = r_state;
        bus.cmd_ready  = 1'b0;
        bus.opnd_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_next_state = (bus.cmd_vl == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                bus.opnd_ready = 1'b1;
                bus.busy       = 1'b1;
                if (bus.opnd_valid && w_last_beat) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (r_drain_cnt == '0) begin
                    bus.done     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, command latch, beat counter and drain countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_opsel     <= '0;
            r_sew       <= '0;
            r_base      <= '0;
            r_beats     <= '0;
            r_last_be   <= '0;
            r_beat_idx  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_cmd_hs) begin
                r_opsel     <= bus.cmd_opsel;
                r_sew       <= bus.cmd_sew;
                r_base      <= bus.cmd_addr;
                r_beats     <= w_beats;
                r_last_be   <= w_last_be;
                r_beat_idx  <= '0;
                // Only matters for vl==0, which skips straight to DRAIN
                r_drain_cnt <= CNT_W'(1);
            end else if (w_opnd_hs) begin
                r_beat_idx <= r_beat_idx + VL_WIDTH'(1);
                if (w_last_beat) begin
                    r_drain_cnt <= CNT_W'(ALU_LATENCY);
                end
            end else if ((r_state == DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - CNT_W'(1);
            end
        end
    end

    // Registered ALU beat; every field is zero on cycles with no handshake
    always_ff @(posedge clk) begin
        if (rst || !w_opnd_hs) begin
            bus.alu_valid     <= 1'b0;
            bus.alu_vec0      <= '0;
            bus.alu_vec1      <= '0;
            bus.alu_sew       <= '0;
            bus.alu_opsel     <= '0;
            bus.alu_addr      <= '0;
            bus.alu_start_idx <= '0;
            bus.alu_req_start <= 1'b0;
            bus.alu_req_end   <= 1'b0;
            bus.alu_be        <= '0;
        end else begin
            bus.alu_valid     <= 1'b1;
            bus.alu_vec0      <= w_vec0;
            bus.alu_vec1      <= w_vec1;
            bus.alu_sew       <= r_sew;
            bus.alu_opsel     <= r_opsel;
            bus.alu_addr      <= w_beat_addr;
            bus.alu_start_idx <= w_start_idx;
            bus.alu_req_start <= (r_beat_idx == '0);
            bus.alu_req_end   <= w_last_beat;
            bus.alu_be        <= w_beat_be;
        end
    end

endmodule

`default_nettype wire

// File: doc/vadd_issue_seq.md
Name: vadd_issue_seq

Overview:
- Issue sequencer for the vector add/min/max/compare ALU pipeline.
- Accepts one vector command (opSel, SEW, vl, destination base address), then pulls operand beat pairs from an operand stream.
- Drives one ALU beat per accepted operand pair: in_valid, addr, byte-enable, start_idx, req_start/req_end.
- Pulses done once the last beat has cleared the fixed-latency ALU pipe.

Parameters:
- DATA_WIDTH, 64, operand/ALU beat width; only 64 is supported.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, destination address width.
- OPSEL_WIDTH, 9, ALU op-select width; bit 8 marks a mask-producing (compare) op.
- VL_WIDTH, 16, vector length width, in elements.
- ALU_LATENCY, 6, cycles from ALU in_valid to ALU out_valid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_opsel  in  OPSEL_WIDTH  ALU operation.
- cmd_sew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_addr  in  ADDR_WIDTH  destination base byte address.
- opnd_valid  in  1  operand pair valid.
- opnd_ready  out  1  operand pair consumed when high with opnd_valid.
- opnd_vec0  in  DATA_WIDTH  operand 0.
- opnd_vec1  in  DATA_WIDTH  operand 1.
- alu_valid  out  1  ALU in_valid.
- alu_vec0  out  DATA_WIDTH  ALU in_vec0.
- alu_vec1  out  DATA_WIDTH  ALU in_vec1.
- alu_sew  out  2  ALU in_sew.
- alu_opsel  out  OPSEL_WIDTH  ALU in_opSel.
- alu_addr  out  ADDR_WIDTH  ALU in_addr.
- alu_start_idx  out  3  ALU in_start_idx.
- alu_req_start  out  1  first beat of the command.
- alu_req_end  out  1  last beat of the command.
- alu_be  out  BE_WIDTH  ALU in_be.
- busy  out  1  a command is in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all counters cleared; drain shift register cleared. Every alu_* output is 0, and busy=0, done=0. cmd_ready=1 in the cycle after reset is released.
- Reset asserted mid-command: abandons the command with no done pulse and no further alu_valid. The same reset state results.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command and compute the beat counts, then go to ISSUE; if vl==0, go to DRAIN with the drain count set to 1 instead.
  - ISSUE: opnd_ready=1. Each operand handshake issues one beat. The handshake on the last beat goes to DRAIN.
  - DRAIN: count ALU_LATENCY cycles after the last beat's alu_valid, then pulse done and return to IDLE.
- cmd_ready=0 and opnd_ready=0 outside IDLE and ISSUE respectively. Both are combinational from state only.
- Beat geometry:
  - Elements per beat epb = 8>>sew.
  - Beat count = ceil(vl/epb).
  - Last-beat element count = vl - (beats-1)*epb, in the range 1..epb.
- All alu_* outputs are registered: one cycle from the operand handshake to alu_valid. alu_valid=0 and all alu data fields=0 on cycles without a handshake.
- alu_vec0/alu_vec1 carry the operand pair; alu_sew and alu_opsel carry the latched command values.
- alu_be:
  - All ones on every beat except the last.
  - Last beat: low (last_elems << sew) bits set.
- Data op (opsel[8]=0): alu_addr = base + 8*beat_idx; alu_start_idx=0.
- Mask op: see Optional Feature.
- alu_req_start=1 only on beat 0. alu_req_end=1 only on the final beat. A single-beat command has both set.
- Operand stream gaps are legal: no issue occurs and ISSUE holds.
- busy=1 in ISSUE and DRAIN, including the done cycle. done is high for exactly one cycle, coincident with the last ALU output beat.
- A back-to-back command is accepted the cycle after done; there is no overlap between commands.
- The beat counter wraps only at VL_WIDTH; vl of up to 2^VL_WIDTH-1 elements is handled without overflow.

Optional Feature:
- Macro: VADD_SEQ_MASK_EN.
- Defined: mask ops are sequenced.
  - alu_start_idx = beat_idx[2:0].
  - alu_addr = base + (beat_idx>>3), i.e. one mask byte per 8 beats.
  - alu_be = all ones on every beat.
- Undefined:
  - opsel[8] is ignored for sequencing; mask ops get data-op addressing and alu_start_idx=0.
  - The mask-sequencing logic is removed.

Decomposition:
- Shared package holds:
  - the SEW encoding constants (SEW_8..SEW_64);
  - the state enum (IDLE/ISSUE/DRAIN);
  - the OPSEL mask-bit index constant (8);
  - an epb/beat-count helper function.
- One natural sub-module: vadd_seq_geom. It is combinational and computes beats, last-beat element count and the last-beat byte-enable from sew/vl.

Test Plan:
- sew=0, vl=20, base=0x100, operands every cycle -> 3 beats at 0x100/0x108/0x110. alu_be=FF,FF,0F. req_start on beat 0, req_end on beat 2. done 6 cycles after the last alu_valid.
- sew=3, vl=1 -> single beat with alu_be=FF, req_start=req_end=1.
- vl=0 -> cmd accepted, no alu_valid, done pulse 1 cycle later, busy high for that interval.
- sew=1, vl=9 with opnd_valid toggling 1,0,1,0 -> beats are issued only on handshakes. alu_be last=03. No alu_valid on gap cycles.
- VADD_SEQ_MASK_EN, opsel=0x100, sew=2, vl=20 -> 10 beats. start_idx 0..7,0,1. addr=base for beats 0-7 and base+1 for beats 8-9.
- rst asserted at beat 2 of 5 -> next cycle all outputs 0, state IDLE, cmd_ready=1, no done.
